// File: rtl/exec_sequencer.sv
// exec_sequencer: FETCH/EXEC control sequencer for the 4-bit uP datapath.
// Memory instructions are stretched with RAM wait states; run/halt/single-step
// control, a wait-state timeout (sticky bus_err) and a retired-instruction count.
//
// state | meaning
// HALT  | idle, no strobes; leaves on run or step unless bus_err is set
// FETCH | load instr/oprnd from program_byte, advance PC
// EXEC  | execute decoded instruction; memory op without ram_ready stalls
// WAIT  | hold the RAM access until ram_ready, or time out into HALT
module exec_sequencer #(
    parameter int unsigned WAIT_MAX     = 8,
    parameter int unsigned RC_W         = 16,
    parameter bit          RUN_ON_RESET = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [3:0]      instr,
    input  logic            c_flag,
    input  logic            z_flag,
    input  logic            ram_ready,
    input  logic            run,
    input  logic            step,
    output logic            fetch_en,
    output logic            IncPC,
    output logic            LoadPC,
    output logic            LoadA,
    output logic            LoadFlags,
    output logic            LoadOut,
    output logic [2:0]      S,
    output logic            csRAM,
    output logic            weRAM,
    output logic            oeALU,
    output logic            oeIN,
    output logic            oeOprnd,
    output logic            halted,
    output logic            bus_err,
    output logic [RC_W-1:0] retired
);

    localparam logic [2:0] S_PASSA = 3'b000;
    localparam logic [2:0] S_SUB   = 3'b001;
    localparam logic [2:0] S_PASSB = 3'b010;
    localparam logic [2:0] S_ADD   = 3'b011;
    localparam logic [2:0] S_NAND  = 3'b100;

    // WAIT cycles remaining after the current one; terminal count 0 means timeout
    localparam logic [7:0] WAIT_LOAD = 8'(WAIT_MAX - 1);

    typedef enum logic [1:0] {ST_HALT, ST_FETCH, ST_EXEC, ST_WAIT} state_t;

    state_t     state;
    logic       one_shot;
    logic [7:0] wait_cnt;
    logic       is_mem;
    logic       load_ok;
    logic       done;

    assign is_mem = instr inside {4'h3, 4'h6, 4'h7, 4'hB, 4'hF};
    assign halted = (state == ST_HALT);

    // Completion and load qualification for the instruction in flight
    always_comb begin
        load_ok = 1'b0;
        done    = 1'b0;
        if (state == ST_EXEC) begin
            load_ok = !is_mem || ram_ready;
            done    = load_ok;
        end else if (state == ST_WAIT) begin
            load_ok = ram_ready;
            done    = ram_ready;
        end
    end

    // Strobe decode from state and opcode; everything is forced low while reset is held
    always_comb begin
        fetch_en  = 1'b0;
        IncPC     = 1'b0;
        LoadPC    = 1'b0;
        LoadA     = 1'b0;
        LoadFlags = 1'b0;
        LoadOut   = 1'b0;
        S         = S_PASSA;
        csRAM     = 1'b0;
        weRAM     = 1'b0;
        oeALU     = 1'b0;
        oeIN      = 1'b0;
        oeOprnd   = 1'b0;
        if (reset) begin
            unique case (state)
                ST_FETCH: begin
                    fetch_en = 1'b1;
                    IncPC    = 1'b1;
                end
                ST_EXEC, ST_WAIT: begin
                    case (instr)
                        4'h0: LoadPC = c_flag;
                        4'h1: LoadPC = ~c_flag;
                        4'h8: LoadPC = z_flag;
                        4'h9: LoadPC = ~z_flag;
                        4'hC: LoadPC = 1'b1;
                        4'h2: begin oeOprnd = 1'b1; S = S_SUB;   LoadFlags = 1'b1; end
                        4'h3: begin csRAM   = 1'b1; S = S_SUB;   LoadFlags = 1'b1; end
                        4'h4: begin oeOprnd = 1'b1; S = S_PASSB; LoadA = 1'b1; LoadFlags = 1'b1; end
                        4'h5: begin oeIN    = 1'b1; S = S_PASSB; LoadA = 1'b1; LoadFlags = 1'b1; end
                        4'h6: begin csRAM   = 1'b1; S = S_PASSB; LoadA = 1'b1; LoadFlags = 1'b1; end
                        4'h7: begin csRAM = 1'b1; weRAM = 1'b1; oeALU = 1'b1; S = S_PASSA; end
                        4'hA: begin oeOprnd = 1'b1; S = S_ADD;   LoadA = 1'b1; LoadFlags = 1'b1; end
                        4'hB: begin csRAM   = 1'b1; S = S_ADD;   LoadA = 1'b1; LoadFlags = 1'b1; end
                        4'hD: begin oeALU   = 1'b1; S = S_PASSA; LoadOut = 1'b1; end
                        4'hE: begin oeOprnd = 1'b1; S = S_NAND;  LoadA = 1'b1; LoadFlags = 1'b1; end
                        4'hF: begin csRAM   = 1'b1; S = S_NAND;  LoadA = 1'b1; LoadFlags = 1'b1; end
                        default: ;
                    endcase
                    if (!load_ok) begin
                        LoadPC    = 1'b0;
                        LoadA     = 1'b0;
                        LoadFlags = 1'b0;
                        LoadOut   = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sequencer state, wait-state timer, sticky bus error and retire counter
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= RUN_ON_RESET ? ST_FETCH : ST_HALT;
            one_shot <= 1'b0;
            wait_cnt <= 8'd0;
            bus_err  <= 1'b0;
            retired  <= '0;
        end else if (done) begin
            retired  <= retired + RC_W'(1);
            state    <= (run && !one_shot) ? ST_FETCH : ST_HALT;
            one_shot <= 1'b0;
        end else begin
            unique case (state)
                ST_HALT: begin
                    if (!bus_err) begin
                        if (run) begin
                            state <= ST_FETCH;
                        end else if (step) begin
                            state    <= ST_FETCH;
                            one_shot <= 1'b1;
                        end
                    end
                end
                ST_FETCH: state <= ST_EXEC;
                ST_EXEC: begin
                    state    <= ST_WAIT;
                    wait_cnt <= WAIT_LOAD;
                end
                ST_WAIT: begin
                    if (wait_cnt == 8'd0) begin
                        bus_err  <= 1'b1;
                        state    <= ST_HALT;
                        one_shot <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                default: state <= ST_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: directed scenarios followed by randomized instruction
// streams, checked cycle by cycle against an instruction-level reference model.
module tb_exec_sequencer;

    localparam int WAIT_MAX = 8;
    localparam int RC_W     = 8;

    localparam logic [2:0] S_PASSA = 3'b000;
    localparam logic [2:0] S_SUB   = 3'b001;
    localparam logic [2:0] S_PASSB = 3'b010;
    localparam logic [2:0] S_ADD   = 3'b011;
    localparam logic [2:0] S_NAND  = 3'b100;

    typedef struct packed {
        logic       fetch_en;
        logic       inc_pc;
        logic       load_pc;
        logic       load_a;
        logic       load_flags;
        logic       load_out;
        logic [2:0] s;
        logic       cs_ram;
        logic       we_ram;
        logic       oe_alu;
        logic       oe_in;
        logic       oe_oprnd;
    } ctl_t;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [3:0]      instr = 4'h0;
    logic            c_flag = 1'b0;
    logic            z_flag = 1'b0;
    logic            ram_ready = 1'b0;
    logic            run = 1'b0;
    logic            step = 1'b0;
    logic            fetch_en, IncPC, LoadPC, LoadA, LoadFlags, LoadOut;
    logic [2:0]      S;
    logic            csRAM, weRAM, oeALU, oeIN, oeOprnd;
    logic            halted, bus_err;
    logic [RC_W-1:0] retired;
    ctl_t            obs;

    int n_checks = 0;
    int n_err    = 0;

    int m_retired  = 0;
    bit m_bus_err  = 1'b0;
    bit m_halted   = 1'b0;
    bit m_one_shot = 1'b0;

    exec_sequencer #(
        .WAIT_MAX     (WAIT_MAX),
        .RC_W         (RC_W),
        .RUN_ON_RESET (1'b1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .instr     (instr),
        .c_flag    (c_flag),
        .z_flag    (z_flag),
        .ram_ready (ram_ready),
        .run       (run),
        .step      (step),
        .fetch_en  (fetch_en),
        .IncPC     (IncPC),
        .LoadPC    (LoadPC),
        .LoadA     (LoadA),
        .LoadFlags (LoadFlags),
        .LoadOut   (LoadOut),
        .S         (S),
        .csRAM     (csRAM),
        .weRAM     (weRAM),
        .oeALU     (oeALU),
        .oeIN      (oeIN),
        .oeOprnd   (oeOprnd),
        .halted    (halted),
        .bus_err   (bus_err),
        .retired   (retired)
    );

    assign obs = {fetch_en, IncPC, LoadPC, LoadA, LoadFlags, LoadOut, S,
                  csRAM, weRAM, oeALU, oeIN, oeOprnd};

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_mem_op(input logic [3:0] op);
        return op inside {4'h3, 4'h6, 4'h7, 4'hB, 4'hF};
    endfunction

    function automatic ctl_t exp_fetch();
        ctl_t e = '0;
        e.fetch_en = 1'b1;
        e.inc_pc   = 1'b1;
        return e;
    endfunction

    // Execute-phase strobes straight from the opcode table
    function automatic ctl_t exp_exec(input logic [3:0] op, input bit c, input bit z,
                                      input bit load_ok);
        ctl_t e = '0;
        case (op)
            4'h0: e.load_pc = c;
            4'h1: e.load_pc = !c;
            4'h8: e.load_pc = z;
            4'h9: e.load_pc = !z;
            4'hC: e.load_pc = 1'b1;
            4'h2: begin e.oe_oprnd = 1; e.s = S_SUB; e.load_flags = 1; end
            4'h3: begin e.cs_ram = 1; e.s = S_SUB; e.load_flags = 1; end
            4'h4: begin e.oe_oprnd = 1; e.s = S_PASSB; e.load_a = 1; e.load_flags = 1; end
            4'h5: begin e.oe_in = 1; e.s = S_PASSB; e.load_a = 1; e.load_flags = 1; end
            4'h6: begin e.cs_ram = 1; e.s = S_PASSB; e.load_a = 1; e.load_flags = 1; end
            4'h7: begin e.cs_ram = 1; e.we_ram = 1; e.oe_alu = 1; e.s = S_PASSA; end
            4'hA: begin e.oe_oprnd = 1; e.s = S_ADD; e.load_a = 1; e.load_flags = 1; end
            4'hB: begin e.cs_ram = 1; e.s = S_ADD; e.load_a = 1; e.load_flags = 1; end
            4'hD: begin e.oe_alu = 1; e.s = S_PASSA; e.load_out = 1; end
            4'hE: begin e.oe_oprnd = 1; e.s = S_NAND; e.load_a = 1; e.load_flags = 1; end
            4'hF: begin e.cs_ram = 1; e.s = S_NAND; e.load_a = 1; e.load_flags = 1; end
            default: ;
        endcase
        if (!load_ok) begin
            e.load_pc    = 1'b0;
            e.load_a     = 1'b0;
            e.load_flags = 1'b0;
            e.load_out   = 1'b0;
        end
        return e;
    endfunction

    // Inputs are already driven; check at the falling edge, then cross the rising edge
    task automatic step_cycle(input string tag, input ctl_t e);
        @(negedge clock);
        chk({tag, ".ctl"},     32'(obs),     32'(e));
        chk({tag, ".halted"},  32'(halted),  32'(m_halted));
        chk({tag, ".bus_err"}, 32'(bus_err), 32'(m_bus_err));
        chk({tag, ".retired"}, 32'(retired), 32'(m_retired));
        @(posedge clock);
        #1;
    endtask

    task automatic retire(input bit run_end);
        m_retired  = (m_retired + 1) % (1 << RC_W);
        m_halted   = !(run_end && !m_one_shot);
        m_one_shot = 1'b0;
    endtask

    task automatic do_reset(input int ncyc);
        reset = 1'b0;
        run = 1'b1;
        step = 1'b0;
        ram_ready = 1'b0;
        @(posedge clock);
        #1;
        m_retired  = 0;
        m_bus_err  = 1'b0;
        m_halted   = 1'b0;
        m_one_shot = 1'b0;
        for (int i = 1; i < ncyc; i++) step_cycle("reset", ctl_t'('0));
        reset = 1'b1;
    endtask

    // nwait = number of not-ready cycles counting the EXEC cycle; abort_at stops
    // before the given WAIT cycle is clocked (used for reset during a stall)
    task automatic do_instr(input logic [3:0] op, input bit cc, input bit zz,
                            input int nwait, input bit run_end, input int abort_at);
        bit mem;
        mem = is_mem_op(op);
        instr = op;
        c_flag = 1'($urandom);
        z_flag = 1'($urandom);
        ram_ready = 1'($urandom);
        run = 1'($urandom);
        step = 1'b0;
        step_cycle("fetch", exp_fetch());
        c_flag = cc;
        z_flag = zz;
        if (!mem || nwait == 0) begin
            ram_ready = mem ? 1'b1 : 1'($urandom);
            run = run_end;
            step_cycle("exec", exp_exec(op, cc, zz, 1'b1));
            retire(run_end);
            return;
        end
        ram_ready = 1'b0;
        run = 1'($urandom);
        step_cycle("exec_stall", exp_exec(op, cc, zz, 1'b0));
        for (int j = 1; j <= WAIT_MAX; j++) begin
            if (j == abort_at) return;
            if (j == nwait) begin
                ram_ready = 1'b1;
                run = run_end;
                step_cycle("wait_done", exp_exec(op, cc, zz, 1'b1));
                retire(run_end);
                return;
            end
            ram_ready = 1'b0;
            run = 1'($urandom);
            step_cycle("wait", exp_exec(op, cc, zz, 1'b0));
        end
        m_bus_err  = 1'b1;
        m_halted   = 1'b1;
        m_one_shot = 1'b0;
    endtask

    task automatic leave_halt(input bit use_step);
        int n_idle;
        n_idle = $urandom_range(0, 2);
        for (int i = 0; i < n_idle; i++) begin
            run = 1'b0;
            step = 1'b0;
            instr = 4'($urandom);
            step_cycle("halt_idle", ctl_t'('0));
        end
        if (use_step) begin
            run = 1'b0;
            step = 1'b1;
        end else begin
            run = 1'b1;
            step = 1'($urandom);
        end
        step_cycle("halt_go", ctl_t'('0));
        m_one_shot = use_step;
        m_halted = 1'b0;
        step = 1'b0;
    endtask

    // After a timeout the sequencer must sit in HALT regardless of run/step
    task automatic post_err();
        for (int i = 0; i < 3; i++) begin
            run = 1'b1;
            step = 1'b1;
            step_cycle("err_hold", ctl_t'('0));
        end
        step = 1'b0;
        do_reset(2);
    endtask

    task automatic random_instr(input bit allow_err);
        logic [3:0] op;
        int nwait;
        bit run_end;
        if (m_halted) leave_halt(1'($urandom));
        op = 4'($urandom);
        nwait = 0;
        if (is_mem_op(op)) begin
            if (allow_err && $urandom_range(0, 24) == 0)
                nwait = WAIT_MAX + 1 + int'($urandom_range(0, 2));
            else
                nwait = int'($urandom_range(0, WAIT_MAX));
        end
        run_end = ($urandom_range(0, 3) != 0);
        do_instr(op, 1'($urandom), 1'($urandom), nwait, run_end, -1);
        if (m_bus_err) post_err();
    endtask

    initial begin
        do_reset(2);
        // LIT straight out of reset, then LD with three not-ready cycles
        do_instr(4'h4, 1'b0, 1'b0, 0, 1'b1, -1);
        do_instr(4'h6, 1'b0, 1'b0, 3, 1'b1, -1);
        // conditional jumps on carry and zero
        do_instr(4'h0, 1'b0, 1'b0, 0, 1'b1, -1);
        do_instr(4'h0, 1'b1, 1'b0, 0, 1'b1, -1);
        do_instr(4'h9, 1'b0, 1'b0, 0, 1'b1, -1);
        // stop at the boundary, then single-step one ADDI even with run high at its end
        do_instr(4'h2, 1'b0, 1'b1, 0, 1'b0, -1);
        leave_halt(1'b1);
        do_instr(4'hA, 1'b0, 1'b0, 0, 1'b1, -1);
        leave_halt(1'b0);
        // ready on the last permitted WAIT cycle, then a store that times out
        do_instr(4'hB, 1'b1, 1'b0, WAIT_MAX, 1'b1, -1);
        do_instr(4'h7, 1'b0, 1'b0, WAIT_MAX + 5, 1'b1, -1);
        post_err();
        // reset in the middle of a stalled access
        do_instr(4'hB, 1'b0, 1'b0, 20, 1'b1, 3);
        do_reset(2);
        // long error-free stream carries the retire counter through its wrap
        for (int i = 0; i < 300; i++) random_instr(1'b0);
        for (int i = 0; i < 200; i++) random_instr(1'b1);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
